// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared encodings and reset-layout constants for the snake game core.
//   - game_state_t : GS_IDLE / GS_PLAY / GS_OVER / GS_WIN (matches the 2-bit
//                    game_state bus consumed by display_vga)
//   - dir_t        : DIR_UP / DIR_DOWN / DIR_LEFT / DIR_RIGHT
//   - COORD_W      : width of one packed coordinate field
//   - RST_*        : restart layout (head, food, length) and LFSR seed
// -----------------------------------------------------------------------------
package snake_pkg;

  localparam int COORD_W = 5;

  typedef enum logic [1:0] {
    GS_IDLE = 2'b00,
    GS_PLAY = 2'b01,
    GS_OVER = 2'b10,
    GS_WIN  = 2'b11
  } game_state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam logic [COORD_W-1:0] RST_HEAD_X = 5'd10;
  localparam logic [COORD_W-1:0] RST_HEAD_Y = 5'd10;
  localparam logic [COORD_W-1:0] RST_FOOD_X = 5'd20;
  localparam logic [COORD_W-1:0] RST_FOOD_Y = 5'd10;
  localparam logic [5:0]         RST_LEN    = 6'd3;
  localparam logic [9:0]         LFSR_SEED  = 10'h2A5;

  function automatic logic is_opposite(input dir_t a, input dir_t b);
    case (a)
      DIR_UP:    return b == DIR_DOWN;
      DIR_DOWN:  return b == DIR_UP;
      DIR_LEFT:  return b == DIR_RIGHT;
      default:   return b == DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snake_food_lfsr.sv
// -----------------------------------------------------------------------------
// snake_food_lfsr
// 10-bit Fibonacci LFSR (taps 10,7) producing food-position candidates.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (loads LFSR_SEED)
//   en           : advance one state this cycle
//   cand_x/cand_y: candidate cell, lfsr[4:0] and lfsr[9:5]
// -----------------------------------------------------------------------------
module snake_food_lfsr
  import snake_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [COORD_W-1:0] cand_x,
  output logic [COORD_W-1:0] cand_y
);

  logic [9:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (en) begin
      lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    end
  end

  assign cand_x = lfsr[4:0];
  assign cand_y = lfsr[9:5];

endmodule

// File: rtl/snake_game_core.sv
// -----------------------------------------------------------------------------
// snake_game_core
// Snake game logic feeding display_vga: body coordinates, length, food and
// game state, advanced one cell per step tick.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   btn_up/down/left/right   : debounced direction request levels
//   btn_start                : debounced start/restart level (rising edge used)
//   food_x, food_y           : food cell
//   snake_x_1dim/snake_y_1dim: segment i at bits [5i+4:5i], i=0 is the head
//   snake_length             : number of valid segments
//   game_state               : 00 IDLE, 01 PLAY, 10 OVER, 11 WIN
// Build option: define SNAKE_WALL_WRAP_EN to make the head wrap around the
// playfield edges instead of dying on them.
// -----------------------------------------------------------------------------
module snake_game_core
  import snake_pkg::*;
#(
  parameter int GRID_W      = 32,
  parameter int GRID_H      = 24,
  parameter int MAX_LEN     = 64,
  parameter int STEP_CYCLES = 5000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_left,
  input  logic                       btn_right,
  input  logic                       btn_start,
  output logic [COORD_W-1:0]         food_x,
  output logic [COORD_W-1:0]         food_y,
  output logic [MAX_LEN*COORD_W-1:0] snake_x_1dim,
  output logic [MAX_LEN*COORD_W-1:0] snake_y_1dim,
  output logic [5:0]                 snake_length,
  output logic [1:0]                 game_state
);

  localparam int BUS_W = MAX_LEN * COORD_W;
  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  // Signed coordinate width must hold -1 .. GRID_W, which 6 bits cannot for 32.
  localparam int SC_W  = COORD_W + 2;
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic signed [SC_W-1:0] GRID_W_S = SC_W'(GRID_W);
  localparam logic signed [SC_W-1:0] GRID_H_S = SC_W'(GRID_H);
  localparam logic signed [SC_W-1:0] ONE_S    = SC_W'(1);
  localparam logic [5:0]             LEN_WIN  = 6'(MAX_LEN - 1);
  localparam logic [BUS_W-1:0] RST_X_BUS =
    {{(BUS_W - 3*COORD_W){1'b0}}, RST_HEAD_X - 5'd2, RST_HEAD_X - 5'd1, RST_HEAD_X};
  localparam logic [BUS_W-1:0] RST_Y_BUS =
    {{(BUS_W - 3*COORD_W){1'b0}}, RST_HEAD_Y, RST_HEAD_Y, RST_HEAD_Y};

  game_state_t        gs;
  dir_t               dir, pending_dir, req_dir;
  logic               req_valid, searching, start_q, start_edge, step_pulse;
  logic [CNT_W-1:0]   step_cnt;
  logic signed [SC_W-1:0] nx_s, ny_s;
  logic [COORD_W-1:0] next_x, next_y, cand_x, cand_y;
  logic               wall_hit, self_hit, eat, cand_ok;

  assign game_state = gs;
  assign start_edge = btn_start & ~start_q;
  assign step_pulse = (gs == GS_PLAY) && !searching && (step_cnt == CNT_LAST);

  snake_food_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en     ((gs == GS_PLAY) && searching),
    .cand_x (cand_x),
    .cand_y (cand_y)
  );

  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_RIGHT;
    if (btn_up)         req_dir = DIR_UP;
    else if (btn_down)  req_dir = DIR_DOWN;
    else if (btn_left)  req_dir = DIR_LEFT;
    else if (btn_right) req_dir = DIR_RIGHT;
    else                req_valid = 1'b0;
  end

  // Step evaluation uses pending_dir, the direction that becomes dir on this step.
  always_comb begin
    nx_s     = $signed({2'b00, snake_x_1dim[COORD_W-1:0]});
    ny_s     = $signed({2'b00, snake_y_1dim[COORD_W-1:0]});
    wall_hit = 1'b0;
    case (pending_dir)
      DIR_UP:   ny_s = ny_s - ONE_S;
      DIR_DOWN: ny_s = ny_s + ONE_S;
      DIR_LEFT: nx_s = nx_s - ONE_S;
      default:  nx_s = nx_s + ONE_S;
    endcase
`ifdef SNAKE_WALL_WRAP_EN
    if (nx_s[SC_W-1])          nx_s = GRID_W_S - ONE_S;
    else if (nx_s >= GRID_W_S) nx_s = '0;
    if (ny_s[SC_W-1])          ny_s = GRID_H_S - ONE_S;
    else if (ny_s >= GRID_H_S) ny_s = '0;
`else
    wall_hit = nx_s[SC_W-1] || (nx_s >= GRID_W_S) || ny_s[SC_W-1] || (ny_s >= GRID_H_S);
`endif
    next_x = nx_s[COORD_W-1:0];
    next_y = ny_s[COORD_W-1:0];
  end

  // The tail cell is vacated by a non-eating move, so it is not an obstacle.
  always_comb begin
    eat      = (next_x == food_x) && (next_y == food_y);
    self_hit = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if ((k < int'(snake_length)) && (eat || (k != int'(snake_length) - 1)) &&
          (snake_x_1dim[k*COORD_W +: COORD_W] == next_x) &&
          (snake_y_1dim[k*COORD_W +: COORD_W] == next_y))
        self_hit = 1'b1;
    end
  end

  always_comb begin
    cand_ok = (int'(cand_x) < GRID_W) && (int'(cand_y) < GRID_H);
    for (int k = 0; k < MAX_LEN; k++) begin
      if ((k < int'(snake_length)) &&
          (snake_x_1dim[k*COORD_W +: COORD_W] == cand_x) &&
          (snake_y_1dim[k*COORD_W +: COORD_W] == cand_y))
        cand_ok = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gs           <= GS_IDLE;
      dir          <= DIR_RIGHT;
      pending_dir  <= DIR_RIGHT;
      searching    <= 1'b0;
      start_q      <= 1'b0;
      step_cnt     <= '0;
      snake_length <= RST_LEN;
      food_x       <= RST_FOOD_X;
      food_y       <= RST_FOOD_Y;
      snake_x_1dim <= RST_X_BUS;
      snake_y_1dim <= RST_Y_BUS;
    end else begin
      start_q <= btn_start;
      case (gs)
        GS_IDLE: begin
          if (start_edge) gs <= GS_PLAY;
        end
        GS_PLAY: begin
          if (req_valid && !is_opposite(req_dir, dir)) pending_dir <= req_dir;
          if (searching) begin
            if (cand_ok) begin
              food_x    <= cand_x;
              food_y    <= cand_y;
              searching <= 1'b0;
            end
          end else if (step_pulse) begin
            step_cnt <= '0;
            dir      <= pending_dir;
            if (wall_hit || self_hit) begin
              gs <= GS_OVER;
            end else begin
              snake_x_1dim <= {snake_x_1dim[BUS_W-COORD_W-1:0], next_x};
              snake_y_1dim <= {snake_y_1dim[BUS_W-COORD_W-1:0], next_y};
              if (eat) begin
                snake_length <= snake_length + 6'd1;
                if (snake_length + 6'd1 == LEN_WIN) gs <= GS_WIN;
                else                                searching <= 1'b1;
              end
            end
          end else begin
            step_cnt <= step_cnt + CNT_W'(1);
          end
        end
        default: begin
          // OVER / WIN: frozen until restart; the LFSR keeps its state.
          if (start_edge) begin
            gs           <= GS_IDLE;
            dir          <= DIR_RIGHT;
            pending_dir  <= DIR_RIGHT;
            searching    <= 1'b0;
            step_cnt     <= '0;
            snake_length <= RST_LEN;
            food_x       <= RST_FOOD_X;
            food_y       <= RST_FOOD_Y;
            snake_x_1dim <= RST_X_BUS;
            snake_y_1dim <= RST_Y_BUS;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_game_core.sv
module tb_snake_game_core;
  localparam int GRID_W  = 32;
  localparam int GRID_H  = 24;
  localparam int MAX_LEN = 64;
  localparam int STEP    = 4;
  localparam int BUS_W   = MAX_LEN * 5;

  logic clk = 1'b0;
  logic rst, btn_up, btn_down, btn_left, btn_right, btn_start;
  logic [4:0] food_x, food_y;
  logic [BUS_W-1:0] snake_x_1dim, snake_y_1dim;
  logic [5:0] snake_length;
  logic [1:0] game_state;

  always #5 clk = ~clk;

  snake_game_core #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .MAX_LEN(MAX_LEN), .STEP_CYCLES(STEP)
  ) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right), .btn_start(btn_start),
    .food_x(food_x), .food_y(food_y), .snake_x_1dim(snake_x_1dim),
    .snake_y_1dim(snake_y_1dim), .snake_length(snake_length), .game_state(game_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- behavioural reference model ----------------
  // Directions: 0 up, 1 down, 2 left, 3 right. States: 0 idle, 1 play, 2 over, 3 win.
  int m_gs, m_cnt, m_dir, m_pend, m_len, m_fx, m_fy, m_lfsr, m_steps;
  bit m_srch, m_sq;
  int qx[$], qy[$];

  function automatic int lfsr_next(int l);
    return ((l << 1) & 'h3FF) | (((l >> 9) ^ (l >> 6)) & 1);
  endfunction

  function automatic int opp(int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit on_body(int x, int y, int lim);
    for (int k = 0; k < lim; k++)
      if (qx[k] == x && qy[k] == y) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_layout();
    m_gs = 0; m_srch = 0; m_cnt = 0; m_dir = 3; m_pend = 3; m_len = 3;
    m_fx = 20; m_fy = 10;
    qx.delete(); qy.delete();
    for (int i = 0; i < MAX_LEN; i++) begin
      qx.push_back(i < 3 ? 10 - i : 0);
      qy.push_back(i < 3 ? 10 : 0);
    end
  endtask

  task automatic model_clock();
    int req, od, nx, ny, cx, cy;
    bit edge_s, eat, hit;
    if (rst) begin
      model_layout(); m_lfsr = 'h2A5; m_sq = 0;
      return;
    end
    edge_s = btn_start && !m_sq;
    m_sq = btn_start;
    req = btn_up ? 0 : btn_down ? 1 : btn_left ? 2 : btn_right ? 3 : -1;
    od = m_dir;
    case (m_gs)
      0: if (edge_s) m_gs = 1;
      1: begin
        if (m_srch) begin
          cx = m_lfsr & 31; cy = (m_lfsr >> 5) & 31;
          if (cx < GRID_W && cy < GRID_H && !on_body(cx, cy, m_len)) begin
            m_fx = cx; m_fy = cy; m_srch = 0;
          end
          m_lfsr = lfsr_next(m_lfsr);
        end else if (m_cnt == STEP - 1) begin
          m_cnt = 0; m_steps++; m_dir = m_pend;
          nx = qx[0] + (m_dir == 2 ? -1 : m_dir == 3 ? 1 : 0);
          ny = qy[0] + (m_dir == 0 ? -1 : m_dir == 1 ? 1 : 0);
          hit = 0;
`ifdef SNAKE_WALL_WRAP_EN
          nx = (nx + GRID_W) % GRID_W;
          ny = (ny + GRID_H) % GRID_H;
`else
          if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) hit = 1;
`endif
          eat = (nx == m_fx) && (ny == m_fy);
          if (on_body(nx, ny, eat ? m_len : m_len - 1)) hit = 1;
          if (hit) m_gs = 2;
          else begin
            qx.push_front(nx); qy.push_front(ny);
            void'(qx.pop_back()); void'(qy.pop_back());
            if (eat) begin
              m_len++;
              if (m_len == MAX_LEN - 1) m_gs = 3;
              else m_srch = 1;
            end
          end
        end else m_cnt++;
        if (req >= 0 && req != opp(od)) m_pend = req;
      end
      default: if (edge_s) model_layout();
    endcase
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic tick();
    logic [BUS_W-1:0] ex, ey;
    model_clock();
    @(posedge clk);
    #1;
    for (int i = 0; i < MAX_LEN; i++) begin
      ex[i*5 +: 5] = 5'(qx[i]);
      ey[i*5 +: 5] = 5'(qy[i]);
    end
    n_tests++;
    if (game_state !== 2'(m_gs) || snake_length !== 6'(m_len) || food_x !== 5'(m_fx) ||
        food_y !== 5'(m_fy) || snake_x_1dim !== ex || snake_y_1dim !== ey) begin
      n_fail++;
      $display("FAIL model t=%0t: state %0d want %0d, len %0d want %0d, food (%0d,%0d) want (%0d,%0d), head (%0d,%0d) want (%0d,%0d), bus_ok x=%0d y=%0d",
               $time, game_state, m_gs, snake_length, m_len, food_x, food_y, m_fx, m_fy,
               snake_x_1dim[4:0], snake_y_1dim[4:0], qx[0], qy[0],
               snake_x_1dim === ex, snake_y_1dim === ey);
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_btn(int code);
    btn_up = (code == 1); btn_down = (code == 2);
    btn_left = (code == 3); btn_right = (code == 4);
  endtask

  // act: 0 = hold btn for nsteps steps, 1 = start pulse, 2 = rst pulse
  // btn: 0 none, 1 up, 2 down, 3 left, 4 right
  typedef struct {
    int act; int btn; int nsteps;
    int ex; int ey; int elen; int egs; int efx; int efy;
  } vec_t;

  vec_t tbl[20];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int target, cyc, bad;
    rst = 1'b1; btn_start = 1'b0; set_btn(0);
    m_steps = 0; m_lfsr = 'h2A5;

    tbl[0]  = '{1, 0, 0, 10, 10, 3, 1, 20, 10};
    tbl[1]  = '{0, 0, 4, 14, 10, 3, 1, 20, 10};
    tbl[2]  = '{0, 3, 1, 15, 10, 3, 1, 20, 10};
    tbl[3]  = '{0, 1, 1, 15,  9, 3, 1, 20, 10};
    tbl[4]  = '{0, 4, 1, 16,  9, 3, 1, 20, 10};
    tbl[5]  = '{0, 2, 1, 16, 10, 3, 1, 20, 10};
    tbl[6]  = '{0, 4, 4, 20, 10, 4, 1,  5, 21};
    tbl[7]  = '{0, 1, 1, 20,  9, 4, 1,  5, 21};
    tbl[8]  = '{0, 3, 1, 19,  9, 4, 1,  5, 21};
    tbl[9]  = '{0, 2, 1, 19, 10, 4, 1,  5, 21};
    tbl[10] = '{0, 2, 11, 19, 21, 4, 1, 5, 21};
    tbl[11] = '{0, 3, 14, 5, 21, 5, 1, 11, 10};
    tbl[12] = '{0, 1, 1,  5, 20, 5, 1, 11, 10};
    tbl[13] = '{0, 4, 1,  6, 20, 5, 1, 11, 10};
    tbl[14] = '{0, 2, 1,  6, 20, 5, 2, 11, 10};
    tbl[15] = '{1, 0, 0, 10, 10, 3, 0, 20, 10};
    tbl[16] = '{1, 0, 0, 10, 10, 3, 1, 20, 10};
    tbl[17] = '{0, 0, 21, 31, 10, 4, 1, 23, 20};
`ifdef SNAKE_WALL_WRAP_EN
    tbl[18] = '{0, 0, 1,  0, 10, 4, 1, 23, 20};
`else
    tbl[18] = '{0, 0, 1, 31, 10, 4, 2, 23, 20};
`endif
    tbl[19] = '{2, 0, 0, 10, 10, 3, 0, 20, 10};

    tick(); tick();
    rst = 1'b0;
    chk("rst_state", game_state, 0);
    chk("rst_len", snake_length, 3);
    chk("rst_food_x", food_x, 20);
    chk("rst_food_y", food_y, 10);
    chk("rst_seg0_x", snake_x_1dim[4:0], 10);
    chk("rst_seg1_x", snake_x_1dim[9:5], 9);
    chk("rst_seg2_x", snake_x_1dim[14:10], 8);
    chk("rst_seg2_y", snake_y_1dim[14:10], 10);
    chk("rst_seg3_x", snake_x_1dim[19:15], 0);

    for (int c = 0; c < 6; c++) tick();
    chk("idle_frozen_head", snake_x_1dim[4:0], 10);
    chk("idle_frozen_state", game_state, 0);

    for (int i = 0; i < 20; i++) begin
      case (tbl[i].act)
        0: begin
          set_btn(tbl[i].btn);
          target = m_steps + tbl[i].nsteps;
          cyc = 0;
          while (m_steps < target && cyc < 400) begin tick(); cyc++; end
          while (m_srch && cyc < 400) begin tick(); cyc++; end
          if (cyc >= 400) begin
            n_tests++; n_fail++;
            $display("FAIL row%0d_timeout: got %0d cycles, expected < 400", i, cyc);
          end
        end
        1: begin set_btn(0); btn_start = 1'b1; tick(); btn_start = 1'b0; tick(); end
        default: begin rst = 1'b1; tick(); rst = 1'b0; tick(); end
      endcase
      chk($sformatf("row%0d_state", i), game_state, tbl[i].egs);
      chk($sformatf("row%0d_len", i), snake_length, tbl[i].elen);
      chk($sformatf("row%0d_head_x", i), snake_x_1dim[4:0], tbl[i].ex);
      chk($sformatf("row%0d_head_y", i), snake_y_1dim[4:0], tbl[i].ey);
      chk($sformatf("row%0d_food_x", i), food_x, tbl[i].efx);
      chk($sformatf("row%0d_food_y", i), food_y, tbl[i].efy);
      bad = (food_x >= GRID_W || food_y >= GRID_H) ? 1 : 0;
      for (int k = 0; k < MAX_LEN; k++)
        if (k < snake_length && snake_x_1dim[k*5 +: 5] == food_x && snake_y_1dim[k*5 +: 5] == food_y)
          bad = 1;
      chk($sformatf("row%0d_food_legal", i), bad, 0);
      if (i == 1) begin
        chk("seg2_x_after_4", snake_x_1dim[14:10], 12);
        chk("seg2_y_after_4", snake_y_1dim[14:10], 10);
      end
    end

    // rst while food search is in progress: reset values win
    btn_start = 1'b1; tick(); btn_start = 1'b0; set_btn(0);
    cyc = 0;
    while (!m_srch && cyc < 200) begin tick(); cyc++; end
    chk("search_reached", m_srch, 1);
    chk("search_len", snake_length, 4);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_search_food_x", food_x, 20);
    chk("rst_search_food_y", food_y, 10);
    chk("rst_search_state", game_state, 0);
    chk("rst_search_len", snake_length, 3);

    // start edge in PLAY is ignored
    btn_start = 1'b1; tick(); btn_start = 1'b0; tick(); tick();
    btn_start = 1'b1; tick(); btn_start = 1'b0; tick();
    chk("start_in_play_ignored", game_state, 1);

    // randomized play against the model
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(7) == 0) begin
        btn_up = 1'($urandom); btn_down = 1'($urandom);
        btn_left = 1'($urandom); btn_right = 1'($urandom);
      end
      btn_start = ($urandom_range(24) == 0);
      rst = ($urandom_range(799) == 0);
      tick();
    end
    rst = 1'b0; btn_start = 1'b0; set_btn(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
